interval_envelope_streamer: RTL and testbench

- Downstream consumer of the interval min/max stage.
- When that stage asserts done, this block snapshots the per-interval min/max results, derives peak-to-peak and clip flags, and streams one record per interval over a valid/ready interface.
- It feeds the envelope/display logic.
- The min/max stage may start its next computation as soon as the snapshot is taken.

---
 rtl/interval_envelope_streamer_pkg.sv | 16 +
 rtl/interval_metric.sv | 27 ++
 rtl/interval_envelope_streamer.sv | 152 +++++++++++++++
 tb/tb_interval_envelope_streamer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interval_envelope_streamer_pkg.sv
// Shared definitions for the interval envelope streamer and its metric helper.
package interval_envelope_streamer_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;

  // Record index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    StIdle   = 1'b0,
    StStream = 1'b1
  } state_e;

endpackage

// File: rtl/interval_metric.sv
// Combinational per-interval metrics: peak-to-peak span and clip detection.
module interval_metric #(
  parameter int unsigned DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] min_val,
  input  logic signed [DATA_W-1:0] max_val,
  input  logic        [DATA_W-1:0] clip_level,
  output logic        [DATA_W:0]   p2p,
  output logic                     clip
);

  logic signed [DATA_W:0]   diff;
  logic signed [DATA_W+1:0] max_x;
  logic signed [DATA_W+1:0] min_x;
  logic signed [DATA_W+1:0] lvl_x;

  // Span clamps to zero for a corrupt min>max set; clip uses two guard bits so -level never wraps.
  always_comb begin
    diff  = {max_val[DATA_W-1], max_val} - {min_val[DATA_W-1], min_val};
    p2p   = diff[DATA_W] ? '0 : diff;
    max_x = {{2{max_val[DATA_W-1]}}, max_val};
    min_x = {{2{min_val[DATA_W-1]}}, min_val};
    lvl_x = {2'b00, clip_level};
    clip  = (max_x >= lvl_x) || (min_x <= -lvl_x);
  end

endmodule

// File: rtl/interval_envelope_streamer.sv
// Snapshots a min/max result set on the done edge and streams one record per interval.
module interval_envelope_streamer
  import interval_envelope_streamer_pkg::*;
#(
  parameter int unsigned NUM_INTERVALS = 10,
  parameter int unsigned DATA_W        = DATA_W_DEFAULT,
  parameter int unsigned IDX_W         = idx_width(NUM_INTERVALS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            mm_done,
  input  logic [NUM_INTERVALS*DATA_W-1:0] in_min,
  input  logic [NUM_INTERVALS*DATA_W-1:0] in_max,
  input  logic [DATA_W-1:0]               clip_level,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [IDX_W-1:0]                out_index,
  output logic signed [DATA_W-1:0]        out_min,
  output logic signed [DATA_W-1:0]        out_max,
  output logic [DATA_W:0]                 out_p2p,
  output logic                            out_clip,
  output logic                            out_last,
  output logic                            busy,
  output logic                            overrun
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_INTERVALS - 1);

  state_e state_q, state_d;
  logic   done_d;
  logic   rise;
  logic   capture;
  logic   load;
  logic   finish;
  logic   overrun_set;
  logic [IDX_W-1:0] next_idx;

  logic signed [DATA_W-1:0] snap_min [NUM_INTERVALS];
  logic signed [DATA_W-1:0] snap_max [NUM_INTERVALS];
  logic        [DATA_W-1:0] snap_clip;

  logic signed [DATA_W-1:0] rec_min;
  logic signed [DATA_W-1:0] rec_max;
  logic        [DATA_W-1:0] rec_clip_level;
  logic        [DATA_W:0]   rec_p2p;
  logic                     rec_clip;

  // Next-state decode and handshake-driven record advance.
  always_comb begin
    rise        = mm_done & ~done_d;
    state_d     = state_q;
    capture     = 1'b0;
    load        = 1'b0;
    finish      = 1'b0;
    overrun_set = 1'b0;
    next_idx    = (out_index == LastIdx) ? '0 : out_index + 1'b1;
    unique case (state_q)
      StIdle: begin
        next_idx = '0;
        if (rise) begin
          capture = 1'b1;
          load    = 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        overrun_set = rise;
        if (out_valid && out_ready) begin
          if (out_last) begin
            finish  = 1'b1;
            state_d = StIdle;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Record 0 comes straight from the inputs at capture; later records from the snapshot.
  always_comb begin
    if (state_q == StIdle) begin
      rec_min        = in_min[DATA_W-1:0];
      rec_max        = in_max[DATA_W-1:0];
      rec_clip_level = clip_level;
    end else begin
      rec_min        = snap_min[next_idx];
      rec_max        = snap_max[next_idx];
      rec_clip_level = snap_clip;
    end
  end

  interval_metric #(
    .DATA_W(DATA_W)
  ) u_metric (
    .min_val   (rec_min),
    .max_val   (rec_max),
    .clip_level(rec_clip_level),
    .p2p       (rec_p2p),
    .clip      (rec_clip)
  );

  // Snapshot registers; contents only matter while streaming, so no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < NUM_INTERVALS; i++) begin
        snap_min[i] <= in_min[i*DATA_W +: DATA_W];
        snap_max[i] <= in_max[i*DATA_W +: DATA_W];
      end
      snap_clip <= clip_level;
    end
  end

  // State, edge detector and output record registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      done_d    <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      out_index <= '0;
      out_min   <= '0;
      out_max   <= '0;
      out_p2p   <= '0;
      out_clip  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_d  <= mm_done;
      if (overrun_set) begin
        overrun <= 1'b1;
      end
      if (load) begin
        out_valid <= 1'b1;
        busy      <= 1'b1;
        out_index <= next_idx;
        out_min   <= rec_min;
        out_max   <= rec_max;
        out_p2p   <= rec_p2p;
        out_clip  <= rec_clip;
        out_last  <= (next_idx == LastIdx);
      end else if (finish) begin
        out_valid <= 1'b0;
        busy      <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_interval_envelope_streamer.sv
// Scoreboard bench: stimulus pushes expected records, a monitor pops on each handshake.
module tb_interval_envelope_streamer;

  localparam int N = 10;
  localparam int W = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 mm_done;
  logic [N*W-1:0]       in_min;
  logic [N*W-1:0]       in_max;
  logic [W-1:0]         clip_level;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           out_index;
  logic signed [W-1:0]  out_min;
  logic signed [W-1:0]  out_max;
  logic [W:0]           out_p2p;
  logic                 out_clip;
  logic                 out_last;
  logic                 busy;
  logic                 overrun;

  interval_envelope_streamer dut (
    .clk       (clk),
    .reset     (reset),
    .mm_done   (mm_done),
    .in_min    (in_min),
    .in_max    (in_max),
    .clip_level(clip_level),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_p2p   (out_p2p),
    .out_clip  (out_clip),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [W-1:0] mn;
    logic [W-1:0] mx;
    logic [W:0]   p2p;
    bit           clip;
    bit           last;
  } rec_t;

  rec_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   mode   = 0;  // 0: ready high, 1: random ready, 2: ready low

  logic signed [W-1:0] set_min [N];
  logic signed [W-1:0] set_max [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Ready generator, changes only just after the active edge.
  always @(posedge clk) begin
    #1;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: record compare on handshake, stability check while stalled.
  bit          stall_prev = 0;
  logic [127:0] held;
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("hold", {out_valid, out_index, out_min, out_max, out_p2p, out_clip, out_last} ==
              held[W*3+8:0] ? 64'd1 : 64'd0, 64'd1);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_record: got index %0d, expected none", out_index);
        end else begin
          rec_t e;
          e = sb.pop_front();
          checks++;
          if (out_index !== 4'(e.idx) || out_min !== e.mn || out_max !== e.mx ||
              out_p2p !== e.p2p || out_clip !== e.clip || out_last !== e.last) begin
            errors++;
            $display("FAIL record: got idx=%0d min=%0h max=%0h p2p=%0h clip=%0b last=%0b, expected idx=%0d min=%0h max=%0h p2p=%0h clip=%0b last=%0b",
                     out_index, out_min, out_max, out_p2p, out_clip, out_last,
                     e.idx, e.mn, e.mx, e.p2p, e.clip, e.last);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      held = '0;
      held[W*3+8:0] = {out_valid, out_index, out_min, out_max, out_p2p, out_clip, out_last};
    end
  end

  // Reference model: plain integer arithmetic on the set being launched.
  task automatic push_expected(input logic [W-1:0] lvl);
    for (int i = 0; i < N; i++) begin
      rec_t   r;
      longint mn, mx, d, l;
      mn = longint'(set_min[i]);
      mx = longint'(set_max[i]);
      l  = longint'({32'b0, lvl});
      d  = mx - mn;
      r.idx  = i;
      r.mn   = set_min[i];
      r.mx   = set_max[i];
      r.p2p  = (d < 0) ? '0 : 33'(d);
      r.clip = (mx >= l) || (mn <= -l);
      r.last = (i == N - 1);
      sb.push_back(r);
    end
  endtask

  task automatic drive_set(input logic [W-1:0] lvl);
    for (int i = 0; i < N; i++) begin
      in_min[i*W +: W] = set_min[i];
      in_max[i*W +: W] = set_max[i];
    end
    clip_level = lvl;
  endtask

  // Launch a set from idle and check the one-cycle valid latency.
  task automatic start_set(input logic [W-1:0] lvl);
    drive_set(lvl);
    push_expected(lvl);
    @(posedge clk); #1;
    mm_done = 1'b1;
    check("valid_before_edge", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("valid_latency", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    mm_done = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: got %0d records pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Arrange for a stall on record k+1 by dropping ready once record k is taken.
  task automatic stall_after(input int k);
    bit hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_index == 4'(k)) begin
        mode = 2;
        hit  = 1;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout: got no record %0d, expected one", k);
    end
  endtask

  initial begin
    reset      = 1'b1;
    mm_done    = 1'b1;
    in_min     = '0;
    in_max     = '0;
    clip_level = '0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_index", 64'(out_index), 64'd0);
    check("rst_p2p", 64'(out_p2p), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    repeat (3) @(posedge clk);
    #1 check("held_done_no_capture", 64'(busy), 64'd0);
    mm_done = 1'b0;

    // Ramp set.
    for (int i = 0; i < N; i++) begin
      set_min[i] = 32'(10 * i);
      set_max[i] = 32'(10 * i + 9);
    end
    start_set(32'd1000);
    wait_drain();

    // Symmetric set at and just above the clip boundary.
    for (int i = 0; i < N; i++) begin
      set_min[i] = -32'sd100;
      set_max[i] = 32'sd100;
    end
    start_set(32'd100);
    wait_drain();
    start_set(32'd101);
    wait_drain();

    // Random sets under random backpressure.
    mode = 1;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < N; i++) begin
        set_min[i] = $signed($urandom_range(0, 4000)) - 32'sd2000;
        set_max[i] = $signed($urandom_range(0, 4000)) - 32'sd2000;
      end
      start_set((s == 0) ? 32'd0 : 32'($urandom_range(0, 2500)));
      wait_drain();
    end
    mode = 0;

    // Extremes, then an inverted min>max set.
    for (int i = 0; i < N; i++) begin
      set_min[i] = 32'h8000_0000;
      set_max[i] = 32'h7FFF_FFFF;
    end
    start_set(32'h7FFF_FFFF);
    wait_drain();
    for (int i = 0; i < N; i++) begin
      set_min[i] = 32'sd5;
      set_max[i] = 32'sd3;
    end
    start_set(32'd1000);
    wait_drain();

    // Overrun while stalled at index 4.
    for (int i = 0; i < N; i++) begin
      set_min[i] = 32'(-7 * i);
      set_max[i] = 32'(50 + 3 * i);
    end
    start_set(32'd60);
    stall_after(3);
    @(negedge clk);
    check("stall_index", 64'(out_index), 64'd4);
    in_min  = {N{32'h1234_5678}};
    in_max  = {N{32'h7654_3210}};
    mm_done = 1'b1;
    @(negedge clk);
    check("overrun_set", 64'(overrun), 64'd1);
    mm_done = 1'b0;
    mode    = 0;
    wait_drain();
    check("overrun_sticky", 64'(overrun), 64'd1);
    for (int i = 0; i < N; i++) begin
      set_min[i] = 32'(i);
      set_max[i] = 32'(i * i);
    end
    start_set(32'd50);
    wait_drain();
    check("overrun_still", 64'(overrun), 64'd1);

    // Reset mid-stream at index 6 with done held high.
    start_set(32'd20);
    stall_after(5);
    @(negedge clk);
    check("stall_index6", 64'(out_index), 64'd6);
    mm_done = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_overrun", 64'(overrun), 64'd0);
    mode = 0;
    repeat (5) @(negedge clk);
    check("no_capture_while_high", 64'(out_valid | busy), 64'd0);
    mm_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_min[i] = -32'(i + 1);
      set_max[i] = 32'(i + 1);
    end
    start_set(32'd5);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
